fwd_hazard_ctrl: RTL

- Operand-forwarding and hazard controller for the 5-stage MIPS pipeline.
- Produces the A/B operand select codes and the store-data select code that EXE consumes, plus the stall/bubble controls for IF/ID.
- Keeps a shadow scoreboard of the EXE and MEM stage destinations, and a multiply/divide busy counter for HI/LO.
- Sits beside ID. It is fed decoded register fields every cycle and drives EXE's select inputs, which are aligned to the instruction currently in EXE.

---
 rtl/fwd_pkg.sv | 34 +++
 rtl/fwd_hazard_ctrl_hazard_scoreboard.sv | 49 ++++
 rtl/fwd_hazard_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings and types for the forwarding/hazard controller.
package fwd_pkg;

    localparam int REG_W          = 5;
    localparam int MULDIV_LAT_DEF = 4;
    localparam int BUSY_W         = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_ID    = 2'd0;
    localparam sel_t SEL_EXMEM = 2'd1;
    localparam sel_t SEL_MEMWB = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wreg;
        logic             regwrite;
        logic             memread;
    } shadow_t;

    // Youngest producer wins; a load one ahead cannot forward from EX/MEM.
    function automatic sel_t fwd_select(input logic used, input logic ex_hit,
                                        input logic ex_load, input logic mem_hit);
        if (!used)
            return SEL_ID;
        else if (ex_hit && !ex_load)
            return SEL_EXMEM;
        else if (mem_hit)
            return SEL_MEMWB;
        else
            return SEL_ID;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_hazard_scoreboard.sv
// Shadow copy of the EXE and MEM destinations, with per-operand "writes r" matches.
module hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_BITS = REG_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                advance,
    input  shadow_t             id_entry,
    input  logic [REG_BITS-1:0] reg_a,
    input  logic [REG_BITS-1:0] reg_b,
    output logic [1:0]          ex_writes,
    output logic [1:0]          mem_writes,
    output logic                ex_load
);

    shadow_t s_ex_reg;
    shadow_t s_mem_reg;
    logic [REG_BITS-1:0] probe [2];

    assign probe[0] = reg_a;
    assign probe[1] = reg_b;

    function automatic logic writes_reg(input shadow_t e, input logic [REG_BITS-1:0] r);
        return e.valid && e.regwrite && (e.wreg == r) && (r != '0);
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_ex_reg  <= '0;
            s_mem_reg <= '0;
        end else begin
            s_mem_reg <= s_ex_reg;
            s_ex_reg  <= advance ? id_entry : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_probe
            assign ex_writes[gi]  = writes_reg(s_ex_reg, probe[gi]);
            assign mem_writes[gi] = writes_reg(s_mem_reg, probe[gi]);
        end
    endgenerate

    assign ex_load = s_ex_reg.valid && s_ex_reg.memread;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding selects, load-use / HI-LO stall control for the 5-stage pipeline.
// Optional FWD_STATS_EN macro adds saturating event counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int REG_BITS   = REG_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ID_Valid,
    input  logic [REG_BITS-1:0] ID_RegA,
    input  logic                ID_UsesA,
    input  logic [REG_BITS-1:0] ID_RegB,
    input  logic                ID_UsesB,
    input  logic                ID_StoreData,
    input  logic [REG_BITS-1:0] ID_WriteReg,
    input  logic                ID_RegWrite,
    input  logic                ID_MemRead,
    input  logic                ID_MulDiv,
    input  logic                ID_ReadHiLo,
    output logic [1:0]          RegA_Select,
    output logic [1:0]          RegB_Select,
    output logic [1:0]          MEM_Data_select,
    output logic                Stall_ID,
    output logic                Bubble_EXE
);

    localparam logic [BUSY_W-1:0] LAT_LOAD = BUSY_W'(MULDIV_LAT);

    shadow_t           id_entry;
    logic [1:0]        ex_writes;
    logic [1:0]        mem_writes;
    logic              ex_load;
    logic              load_use;
    logic              busy_stall;
    logic              stall;
    sel_t              sel_a_next;
    sel_t              sel_b_next;
    sel_t              sel_md_next;
    logic [BUSY_W-1:0] busy_cnt_reg;
    logic [BUSY_W-1:0] busy_cnt_next;

    assign id_entry = '{valid: ID_Valid, wreg: ID_WriteReg,
                        regwrite: ID_RegWrite, memread: ID_MemRead};

    hazard_scoreboard #(.REG_BITS(REG_BITS)) u_scoreboard (
        .CLK        (CLK),
        .RESET      (RESET),
        .advance    (!stall),
        .id_entry   (id_entry),
        .reg_a      (ID_RegA),
        .reg_b      (ID_RegB),
        .ex_writes  (ex_writes),
        .mem_writes (mem_writes),
        .ex_load    (ex_load)
    );

    always_comb begin
        load_use   = ID_Valid && ex_load &&
                     ((ID_UsesA && ex_writes[0]) || (ID_UsesB && ex_writes[1]));
        busy_stall = ID_Valid && (ID_ReadHiLo || ID_MulDiv) && (busy_cnt_reg != '0);
        stall      = load_use || busy_stall;

        sel_a_next  = SEL_ID;
        sel_b_next  = SEL_ID;
        sel_md_next = SEL_ID;
        if (!stall) begin
            sel_a_next = fwd_select(ID_Valid && ID_UsesA, ex_writes[0], ex_load, mem_writes[0]);
            // Store data travels on the B path, so a non-load producer is forwarded there too.
            sel_b_next = fwd_select(ID_Valid && (ID_UsesB || ID_StoreData),
                                    ex_writes[1], ex_load, mem_writes[1]);
            // Load feeding a store: bypass WB result into MEM instead of stalling.
            if (ID_Valid && ID_StoreData && ex_load && ex_writes[1])
                sel_md_next = SEL_EXMEM;
        end

        busy_cnt_next = busy_cnt_reg;
        if (!stall && ID_Valid && ID_MulDiv)
            busy_cnt_next = LAT_LOAD;
        else if (busy_cnt_reg != '0)
            busy_cnt_next = busy_cnt_reg - BUSY_W'(1);
    end

    assign Stall_ID   = stall;
    assign Bubble_EXE = stall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RegA_Select     <= SEL_ID;
            RegB_Select     <= SEL_ID;
            MEM_Data_select <= SEL_ID;
            busy_cnt_reg    <= '0;
        end else begin
            RegA_Select     <= sel_a_next;
            RegB_Select     <= sel_b_next;
            MEM_Data_select <= sel_md_next;
            busy_cnt_reg    <= busy_cnt_next;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] loaduse_stalls;
    logic [31:0] fwd_exmem;
    logic [31:0] fwd_memwb;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cycles   <= '0;
            loaduse_stalls <= '0;
            fwd_exmem      <= '0;
            fwd_memwb      <= '0;
        end else begin
            stall_cycles   <= sat_inc(stall_cycles, stall);
            loaduse_stalls <= sat_inc(loaduse_stalls, load_use);
            fwd_exmem      <= sat_inc(fwd_exmem,
                                      (sel_a_next == SEL_EXMEM) || (sel_b_next == SEL_EXMEM));
            fwd_memwb      <= sat_inc(fwd_memwb,
                                      (sel_a_next == SEL_MEMWB) || (sel_b_next == SEL_MEMWB));
        end
    end
`endif

endmodule
